rv32i_decode_exec_unit: RTL and testbench

- Combined ID/EX datapath block for the 5-stage RV32I core: instruction decoder, 32x32 register file and ALU in one module.
- ID side: takes the IF/ID instruction word and produces control signals, the immediate and register operands; the core latches these into ID/EX registers.
- EX side: takes operands from ID/EX registers and produces result and zero.
- Register write port is driven from WB.

---
 rtl/rv32i_decode_exec_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_rv32i_decode_exec_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode_exec_unit.sv
// ---------------------------------------------------------------------------
// rv32i_decode_exec_unit
// Combined ID/EX datapath block for a 5-stage RV32I core: instruction decoder,
// 32x32 register file (async read, write-back port, same-cycle bypass) and ALU.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-low reset
//   instr_raw         IF/ID instruction word (decoder + register read indices)
//   branch, mem_read, mem_write, alu_op, alu_src, reg_write, imm, illegal
//                     combinational decode of instr_raw
//   rs1_val, rs2_val  register values for instr_raw[19:15] / instr_raw[24:20]
//   rd_addr, w_en, w_val
//                     write-back port from WB
//   ex_alu_op, ex_src1, ex_src2
//                     ALU inputs from the ID/EX registers
//   result, zero      combinational ALU result and result==0 flag
// ---------------------------------------------------------------------------
module rv32i_decode_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr_raw,
    output logic            branch,
    output logic            mem_read,
    output logic            mem_write,
    output logic [3:0]      alu_op,
    output logic            alu_src,
    output logic            reg_write,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    input  logic            w_en,
    input  logic [XLEN-1:0] w_val,
    input  logic [3:0]      ex_alu_op,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_src2,
    output logic            zero,
    output logic [XLEN-1:0] result
);

    localparam int unsigned IDX_W   = 5;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned IMM12_W = 12;
    localparam int unsigned IMM13_W = 13;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // -----------------------------------------------------------------------
    // Instruction fields and immediates
    // -----------------------------------------------------------------------
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [IDX_W-1:0]   rs1_idx;
    logic [IDX_W-1:0]   rs2_idx;
    logic [XLEN-1:0]    imm_i;
    logic [XLEN-1:0]    imm_s;
    logic [XLEN-1:0]    imm_b;
    logic [XLEN-1:0]    imm_shamt;
    logic               is_shift_f3;

    assign opcode    = instr_raw[6:0];
    assign funct3    = instr_raw[14:12];
    assign funct7    = instr_raw[31:25];
    assign rs1_idx   = instr_raw[19:15];
    assign rs2_idx   = instr_raw[24:20];

    assign imm_i     = {{(XLEN-IMM12_W){instr_raw[31]}}, instr_raw[31:20]};
    assign imm_s     = {{(XLEN-IMM12_W){instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
    assign imm_b     = {{(XLEN-IMM13_W){instr_raw[31]}}, instr_raw[31], instr_raw[7],
                        instr_raw[30:25], instr_raw[11:8], 1'b0};
    assign imm_shamt = XLEN'(instr_raw[24:20]);

    assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

    // funct3 -> ALU op; alt selects SUB (f3=000) or SRA (f3=101)
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // -----------------------------------------------------------------------
    // Decoder: purely combinational, defaults describe an inert instruction
    // -----------------------------------------------------------------------
    always_comb begin
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        imm       = '0;
        illegal   = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    reg_write = 1'b1;
                    alu_op    = alu_from_f3(funct3, 1'b0);
                end else if ((funct7 == F7_ALT) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    reg_write = 1'b1;
                    alu_op    = alu_from_f3(funct3, 1'b1);
                end else begin
                    illegal   = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                // f3=000 is always ADDI; only f3=101 honours funct7[5] (SRAI)
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_op    = alu_from_f3(funct3, (funct3 == 3'b101) && instr_raw[30]);
                imm       = is_shift_f3 ? imm_shamt : imm_i;
            end

            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    alu_src   = 1'b1;
                    mem_read  = 1'b1;
                    reg_write = 1'b1;
                    imm       = imm_i;
                end else begin
                    illegal   = 1'b1;
                end
            end

            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                    imm       = imm_s;
                end else begin
                    illegal   = 1'b1;
                end
            end

            OPC_BRANCH: begin
                if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
                    branch    = 1'b1;
                    alu_op    = ALU_SUB;
                    imm       = imm_b;
                end else begin
                    illegal   = 1'b1;
                end
            end

            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREGS];
    logic            wr_live;

    // A write is effective only outside reset and never to x0
    assign wr_live = reset && w_en && (rd_addr != '0);

    // Synchronous clear on reset; reset wins over a simultaneous write
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[rd_addr] <= w_val;
        end
    end

    // Read port 1 with write-back bypass
    always_comb begin
        rs1_val = '0;
        if (rs1_idx == '0) begin
            rs1_val = '0;
        end else if (wr_live && (rd_addr == rs1_idx)) begin
            rs1_val = w_val;
        end else begin
            rs1_val = regs[rs1_idx];
        end
    end

    // Read port 2 with write-back bypass
    always_comb begin
        rs2_val = '0;
        if (rs2_idx == '0) begin
            rs2_val = '0;
        end else if (wr_live && (rd_addr == rs2_idx)) begin
            rs2_val = w_val;
        end else begin
            rs2_val = regs[rs2_idx];
        end
    end

    // -----------------------------------------------------------------------
    // ALU: combinational; shifts look at the low five bits of src2 only
    // -----------------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;

    assign shamt = ex_src2[SHAMT_W-1:0];

    always_comb begin
        result = '0;
        case (ex_alu_op)
            ALU_ADD:  result = ex_src1 + ex_src2;
            ALU_SUB:  result = ex_src1 - ex_src2;
            ALU_SLL:  result = ex_src1 << shamt;
            ALU_SLT:  result = XLEN'($signed(ex_src1) < $signed(ex_src2));
            ALU_SLTU: result = XLEN'(ex_src1 < ex_src2);
            ALU_XOR:  result = ex_src1 ^ ex_src2;
            ALU_SRL:  result = ex_src1 >> shamt;
            ALU_SRA:  result = XLEN'($signed(ex_src1) >>> shamt);
            ALU_OR:   result = ex_src1 | ex_src2;
            ALU_AND:  result = ex_src1 & ex_src2;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_rv32i_decode_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32i_decode_exec_unit
// Directed and randomized checks of decoder, register file and ALU against a
// reference model built from the instruction-set rules.
// ---------------------------------------------------------------------------
module tb_rv32i_decode_exec_unit;

    logic        clock;
    logic        reset;
    logic [31:0] instr_raw;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        w_en;
    logic [31:0] w_val;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic        zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    // reference register contents
    logic [31:0] mdl [32];

    // funct3 -> ALU op for the non-alternate encodings
    logic [3:0] base_tbl [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    rv32i_decode_exec_unit dut (
        .clock     (clock),
        .reset     (reset),
        .instr_raw (instr_raw),
        .branch    (branch),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .reg_write (reg_write),
        .imm       (imm),
        .illegal   (illegal),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_addr   (rd_addr),
        .w_en      (w_en),
        .w_val     (w_val),
        .ex_alu_op (ex_alu_op),
        .ex_src1   (ex_src1),
        .ex_src2   (ex_src2),
        .zero      (zero),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // clock edge plus model update from the inputs present at that edge
    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (w_en && rd_addr != 5'd0) begin
            mdl[rd_addr] = w_val;
        end
        #1;
    endtask

    function automatic logic [31:0] rf_expect(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (reset && w_en && rd_addr == idx) return w_val;
        return mdl[idx];
    endfunction

    task automatic rf_chk(input string tag);
        #1;
        chk({tag, ".rs1"}, rs1_val, rf_expect(instr_raw[19:15]));
        chk({tag, ".rs2"}, rs2_val, rf_expect(instr_raw[24:20]));
    endtask

    function automatic logic [31:0] sext(input int unsigned v, input int unsigned bits);
        int signed s;
        s = int'(v);
        if (v >= (32'd1 << (bits - 1))) s = s - int'(32'd1 << bits);
        return 32'(s);
    endfunction

    task automatic dec_chk(input string tag, input logic [31:0] ins,
                           input logic br, input logic mr, input logic mw,
                           input logic [3:0] op, input logic src, input logic rw,
                           input logic [31:0] im, input logic ill);
        instr_raw = ins;
        #1;
        chk({tag, ".branch"},    32'(branch),    32'(br));
        chk({tag, ".mem_read"},  32'(mem_read),  32'(mr));
        chk({tag, ".mem_write"}, 32'(mem_write), 32'(mw));
        chk({tag, ".alu_op"},    32'(alu_op),    32'(op));
        chk({tag, ".alu_src"},   32'(alu_src),   32'(src));
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
        chk({tag, ".imm"},       imm,            im);
        chk({tag, ".illegal"},   32'(illegal),   32'(ill));
    endtask

    // reference ALU written from the operation definitions
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a + (~b + 32'd1);
            4'd2: r = a * (32'd1 << sh);
            4'd3: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd4: r = (a < b) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = a / (32'd1 << sh);
            4'd7: begin
                r = a / (32'd1 << sh);
                if (a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        ex_alu_op = op;
        ex_src1   = a;
        ex_src2   = b;
        #1;
        chk({tag, ".result"}, result, exp);
        chk({tag, ".zero"}, 32'(zero), (exp == 32'h0) ? 32'd1 : 32'd0);
    endtask

    // build a random instruction from its class and check the decode
    task automatic rand_dec();
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [6:0]  f7, opc;
        logic [11:0] i12;
        logic [12:0] i13;
        logic        alt;
        int unsigned kind;
        kind = $urandom_range(0, 5);
        rd   = 5'($urandom);
        rs1  = 5'($urandom);
        rs2  = 5'($urandom);
        sh   = 5'($urandom);
        f3   = 3'($urandom);
        i12  = 12'($urandom);
        case (kind)
            0: begin
                alt = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom) : 1'b0;
                f7  = alt ? 7'h20 : 7'h00;
                dec_chk("r_op", {f7, rs2, rs1, f3, rd, 7'h33}, 0, 0, 0,
                        alt ? ((f3 == 3'd0) ? 4'd1 : 4'd7) : base_tbl[f3], 0, 1, 32'h0, 0);
            end
            1: begin
                if (f3 == 3'd1) begin
                    dec_chk("r_opimm_sll", {7'h00, sh, rs1, f3, rd, 7'h13}, 0, 0, 0,
                            4'd2, 1, 1, 32'(sh), 0);
                end else if (f3 == 3'd5) begin
                    alt = 1'($urandom);
                    dec_chk("r_opimm_sr", {alt ? 7'h20 : 7'h00, sh, rs1, f3, rd, 7'h13},
                            0, 0, 0, alt ? 4'd7 : 4'd6, 1, 1, 32'(sh), 0);
                end else begin
                    dec_chk("r_opimm", {i12, rs1, f3, rd, 7'h13}, 0, 0, 0,
                            base_tbl[f3], 1, 1, sext(32'(i12), 12), 0);
                end
            end
            2: dec_chk("r_load", {i12, rs1, 3'b010, rd, 7'h03}, 0, 1, 0, 4'd0, 1, 1,
                       sext(32'(i12), 12), 0);
            3: dec_chk("r_store", {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23},
                       0, 0, 1, 4'd0, 1, 0, sext(32'(i12), 12), 0);
            4: begin
                i13 = {i12, 1'b0};
                f3  = 3'(1'($urandom));
                dec_chk("r_branch", {i13[12], i13[10:5], rs2, rs1, f3, i13[4:1], i13[11], 7'h63},
                        1, 0, 0, 4'd1, 0, 0, sext(32'(i13), 13), 0);
            end
            default: begin
                case ($urandom_range(0, 3))
                    0: begin
                        do opc = 7'($urandom);
                        while (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 ||
                               opc == 7'h23 || opc == 7'h63);
                        instr_raw = {i12, rs1, f3, rd, opc};
                    end
                    1: begin
                        if (f3 == 3'b010) f3 = 3'b011;
                        instr_raw = {i12, rs1, f3, rd, ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23};
                    end
                    2: begin
                        f3 = 3'($urandom_range(2, 7));
                        instr_raw = {i12, rs1, f3, rd, 7'h63};
                    end
                    default: begin
                        do f7 = 7'($urandom);
                        while (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                        instr_raw = {f7, rs2, rs1, f3, rd, 7'h33};
                    end
                endcase
                dec_chk("r_illegal", instr_raw, 0, 0, 0, 4'd0, 0, 0, 32'h0, 1);
            end
        endcase
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        reset     = 1'b0;
        instr_raw = 32'h0;
        rd_addr   = 5'd0;
        w_en      = 1'b0;
        w_val     = 32'h0;
        ex_alu_op = 4'd0;
        ex_src1   = 32'h0;
        ex_src2   = 32'h0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'hx;

        // reset state
        tick();
        dec_chk("rst_nop", 32'h0, 0, 0, 0, 4'd0, 0, 0, 32'h0, 1);
        chk("rst.rs1", rs1_val, 32'h0);
        // write attempt during reset: no bypass, and reset wins at the edge
        w_en = 1'b1; rd_addr = 5'd3; w_val = 32'hDEAD_BEEF;
        instr_raw = {7'h00, 5'd3, 5'd3, 3'b000, 5'd1, 7'h33};
        #1;
        chk("rst_bypass.rs1", rs1_val, 32'h0);
        chk("rst_bypass.rs2", rs2_val, 32'h0);
        tick();
        reset = 1'b1; w_en = 1'b0;
        #1;
        chk("rst_over_write.rs1", rs1_val, 32'h0);
        for (int i = 0; i < 32; i += 7) begin
            instr_raw = {7'h00, 5'(31 - i), 5'(i), 3'b000, 5'd1, 7'h33};
            rf_chk("post_rst");
        end

        // register write, read, bypass, x0
        w_en = 1'b1; rd_addr = 5'd5; w_val = 32'h1234_5678;
        tick();
        w_en = 1'b0;
        dec_chk("add", 32'h0052_8533, 0, 0, 0, 4'd0, 0, 1, 32'h0, 0);
        chk("add.rs1", rs1_val, 32'h1234_5678);
        chk("add.rs2", rs2_val, 32'h1234_5678);
        w_en = 1'b1; rd_addr = 5'd5; w_val = 32'h0000_00AA;
        #1;
        chk("bypass.rs1", rs1_val, 32'h0000_00AA);
        chk("bypass.rs2", rs2_val, 32'h0000_00AA);
        tick();
        rd_addr = 5'd0; w_val = 32'hFFFF_FFFF;
        instr_raw = 32'h0000_0033;
        #1;
        chk("x0_wr_bypass.rs1", rs1_val, 32'h0);
        tick();
        w_en = 1'b0;
        #1;
        chk("x0_after.rs1", rs1_val, 32'h0);
        instr_raw = 32'h0052_8533;
        #1;
        chk("x5_kept.rs1", rs1_val, 32'h0000_00AA);

        // directed decodes
        dec_chk("addi", 32'hFFC1_0093, 0, 0, 0, 4'd0, 1, 1, 32'hFFFF_FFFC, 0);
        dec_chk("sw",   32'hFE20_AE23, 0, 0, 1, 4'd0, 1, 0, 32'hFFFF_FFFC, 0);
        dec_chk("beq",  32'hFE20_8EE3, 1, 0, 0, 4'd1, 0, 0, 32'hFFFF_FFFC, 0);
        dec_chk("srai", 32'h4051_5093, 0, 0, 0, 4'd7, 1, 1, 32'h0000_0005, 0);
        dec_chk("op_f7alt_f3_1", {7'h20, 5'd2, 5'd1, 3'b001, 5'd3, 7'h33},
                0, 0, 0, 4'd0, 0, 0, 32'h0, 1);
        dec_chk("sub", {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 0, 0, 0, 4'd1, 0, 1, 32'h0, 0);
        dec_chk("lw", {12'h7FF, 5'd1, 3'b010, 5'd2, 7'h03}, 0, 1, 0, 4'd0, 1, 1, 32'h0000_07FF, 0);
        dec_chk("lb_illegal", {12'h004, 5'd1, 3'b000, 5'd2, 7'h03}, 0, 0, 0, 4'd0, 0, 0, 32'h0, 1);

        // directed ALU
        alu_chk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu_chk("sub_neg",  4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_chk("slt",      4'd3, 32'h8000_0000, 32'h1, 32'h1);
        alu_chk("sltu",     4'd4, 32'h8000_0000, 32'h1, 32'h0);
        alu_chk("sra",      4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_chk("srl",      4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_chk("sll33",    4'd2, 32'h0000_0003, 32'd33, 32'h0000_0006);
        alu_chk("op12",     4'd12, 32'h1234_5678, 32'h1, 32'h0);

        // randomized register file traffic
        for (int n = 0; n < 300; n++) begin
            w_en    = 1'($urandom);
            rd_addr = 5'($urandom);
            w_val   = $urandom;
            instr_raw = $urandom;
            if (n % 5 == 0) instr_raw[19:15] = rd_addr;
            rf_chk("r_rf");
            tick();
        end
        w_en = 1'b0;

        // randomized ALU
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom);
            a  = (n % 4 == 0) ? {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'h0} : $urandom;
            b  = (n % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (n % 7 == 0) b = a;
            alu_chk("r_alu", op, a, b, alu_ref(op, a, b));
        end

        // randomized decode
        for (int n = 0; n < 200; n++) rand_dec();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
